// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int          DEFAULT_PC_W = 16;
    localparam logic [16:0] NOP_INSTR    = 17'h00000;  // LLB R0,#0

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MOVC = 2'd1,
        HALT = 2'd2
    } fsm_state_e;

    // One-hot PC update select; halt outranks load, load outranks hold.
    typedef struct packed {
        logic halt;
        logic load;
        logic hold;
    } pc_ctrl_t;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory port shared by normal fetch and MOVC/LWI reads.
interface if_fetch_if #(
    parameter int PC_W = if_pkg::DEFAULT_PC_W
);
    logic [PC_W-1:0] im_addr;
    logic [16:0]     im_rd_data;

    modport master (output im_addr, input im_rd_data);
    modport slave  (input im_addr, output im_rd_data);
endinterface

// File: rtl/if_fetch_pc_reg.sv
// Program counter with priority halt / load / hold / increment update.
module pc_reg
    import if_pkg::*;
#(
    parameter int              PC_W   = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_ctrl_t        ctrl,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        // NOTE: default assigned first so no path leaves pc_d unassigned (no latch).
        pc_d = pc_q + PC_W'(1);
        if (ctrl.halt)      pc_d = pc_q;
        else if (ctrl.load) pc_d = load_val;
        else if (ctrl.hold) pc_d = pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every flop samples pre-edge values, independent of block order.
        if (!rst_n) pc_q <= RST_PC;
        else        pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, IM port mux, next-PC pipeline and MOVC/LWI reads.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch
    import if_pkg::*;
#(
    parameter int              PC_W   = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_IM_ID,
    input  logic             flow_change_ID_EX,
    input  logic [PC_W-1:0]  dst_ID_EX,
    input  logic             LWI_instr_EX_DM,
    input  logic [PC_W-1:0]  movc_addr_EX_DM,
    input  logic             hlt_DM_WB,
    if_fetch_if.master       im_bus,
    output logic [16:0]      instr,
    output logic [PC_W-1:0]  nxt_pc_IM_ID,
    output logic [PC_W-1:0]  nxt_pc_ID_EX,
    output logic [15:0]      movc_data_DM_WB,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]      fetch_cnt,
    output logic [15:0]      flush_cnt,
`endif
    output logic             halted
);

    fsm_state_e      state_q, state_d;
    logic            in_run, in_movc, in_halt;
    pc_ctrl_t        pc_ctrl;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] nxt_pc_im_id_q, nxt_pc_im_id_d;
    logic [PC_W-1:0] nxt_pc_id_ex_q, nxt_pc_id_ex_d;
    logic [15:0]     movc_data_q, movc_data_d;

    assign in_run  = (state_q == RUN);
    assign in_movc = (state_q == MOVC);
    assign in_halt = (state_q == HALT);

    // A MOVC lasts one cycle; LWI seen while in MOVC is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (hlt_DM_WB) state_d = HALT;
                     else if (LWI_instr_EX_DM) state_d = MOVC;
            MOVC:    state_d = hlt_DM_WB ? HALT : RUN;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        pc_ctrl.halt = in_halt;
        pc_ctrl.load = !in_halt && flow_change_ID_EX;
        pc_ctrl.hold = !in_halt && !flow_change_ID_EX && (in_movc || stall_IM_ID);
    end

    pc_reg #(
        .PC_W   (PC_W),
        .RST_PC (RST_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .ctrl     (pc_ctrl),
        .load_val (dst_ID_EX),
        .pc       (pc)
    );

    assign im_bus.im_addr = in_movc ? movc_addr_EX_DM : pc;
    assign instr          = in_run ? im_bus.im_rd_data : NOP_INSTR;

    // ID_EX never stalls, so its next-PC copy advances every cycle.
    always_comb begin
        nxt_pc_im_id_d = stall_IM_ID ? nxt_pc_im_id_q : pc + PC_W'(1);
        nxt_pc_id_ex_d = nxt_pc_im_id_q;
        movc_data_d    = in_movc ? im_bus.im_rd_data[15:0] : movc_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt_pc_im_id_q <= '0;
            nxt_pc_id_ex_q <= '0;
            movc_data_q    <= '0;
        end else begin
            nxt_pc_im_id_q <= nxt_pc_im_id_d;
            nxt_pc_id_ex_q <= nxt_pc_id_ex_d;
            movc_data_q    <= movc_data_d;
        end
    end

    assign nxt_pc_IM_ID    = nxt_pc_im_id_q;
    assign nxt_pc_ID_EX    = nxt_pc_id_ex_q;
    assign movc_data_DM_WB = movc_data_q;
    assign halted          = in_halt;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters; both freeze once halted.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (in_run && !stall_IM_ID && (fetch_cnt_q != '1))
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (!in_halt && flow_change_ID_EX && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized traffic
// against a cycle-level reference model of the fetch-stage rules.
module tb_if_fetch;

    localparam int PC_W   = 16;
    localparam int M_RUN  = 0;
    localparam int M_MOVC = 1;
    localparam int M_HALT = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall_IM_ID;
    logic            flow_change_ID_EX;
    logic [PC_W-1:0] dst_ID_EX;
    logic            LWI_instr_EX_DM;
    logic [PC_W-1:0] movc_addr_EX_DM;
    logic            hlt_DM_WB;
    logic [16:0]     instr;
    logic [PC_W-1:0] nxt_pc_IM_ID;
    logic [PC_W-1:0] nxt_pc_ID_EX;
    logic [15:0]     movc_data_DM_WB;
    logic            halted;
`ifdef IF_PERF_CNT_EN
    logic [31:0]     fetch_cnt;
    logic [15:0]     flush_cnt;
`endif

    always #5 clk = ~clk;

    if_fetch_if #(.PC_W(PC_W)) im_bus ();

    logic [16:0] mem [0:65535];
    assign im_bus.im_rd_data = mem[im_bus.im_addr];

    if_fetch #(.PC_W(PC_W), .RST_PC(16'h0000)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_IM_ID       (stall_IM_ID),
        .flow_change_ID_EX (flow_change_ID_EX),
        .dst_ID_EX         (dst_ID_EX),
        .LWI_instr_EX_DM   (LWI_instr_EX_DM),
        .movc_addr_EX_DM   (movc_addr_EX_DM),
        .hlt_DM_WB         (hlt_DM_WB),
        .im_bus            (im_bus),
        .instr             (instr),
        .nxt_pc_IM_ID      (nxt_pc_IM_ID),
        .nxt_pc_ID_EX      (nxt_pc_ID_EX),
        .movc_data_DM_WB   (movc_data_DM_WB),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt         (fetch_cnt),
        .flush_cnt         (flush_cnt),
`endif
        .halted            (halted)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] m_pc, m_nxt1, m_nxt2, m_movc, m_flush;
    logic [31:0] m_fetch;
    int          m_mode;

    function automatic logic [15:0] exp_addr();
        return (m_mode == M_MOVC) ? movc_addr_EX_DM : m_pc;
    endfunction

    function automatic logic [16:0] exp_instr();
        return (m_mode == M_RUN) ? mem[exp_addr()] : 17'h00000;
    endfunction

    task automatic set_idle();
        stall_IM_ID = 0; flow_change_ID_EX = 0; dst_ID_EX = '0;
        LWI_instr_EX_DM = 0; movc_addr_EX_DM = '0; hlt_DM_WB = 0;
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_nxt1 = '0; m_nxt2 = '0; m_movc = '0;
        m_mode = M_RUN; m_fetch = '0; m_flush = '0;
    endtask

    // Reset asserted mid-cycle; released on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Apply one clock edge to both model and DUT using the inputs now driven.
    task automatic tick();
        logic [15:0] n_pc, n_nxt1, n_nxt2, n_movc, n_flush;
        logic [31:0] n_fetch;
        int          n_mode;
        n_pc = m_pc;
        if (m_mode != M_HALT) begin
            if (flow_change_ID_EX)                     n_pc = dst_ID_EX;
            else if (m_mode != M_MOVC && !stall_IM_ID) n_pc = m_pc + 16'd1;
        end
        n_nxt1 = stall_IM_ID ? m_nxt1 : m_pc + 16'd1;
        n_nxt2 = m_nxt1;
        n_movc = (m_mode == M_MOVC) ? mem[movc_addr_EX_DM][15:0] : m_movc;
        if (m_mode == M_HALT || hlt_DM_WB)            n_mode = M_HALT;
        else if (m_mode == M_RUN && LWI_instr_EX_DM)  n_mode = M_MOVC;
        else                                          n_mode = M_RUN;
        n_fetch = m_fetch;
        n_flush = m_flush;
        if (m_mode == M_RUN && !stall_IM_ID && m_fetch != 32'hFFFF_FFFF) n_fetch = m_fetch + 1;
        if (m_mode != M_HALT && flow_change_ID_EX && m_flush != 16'hFFFF) n_flush = m_flush + 1;
        @(posedge clk);
        m_pc = n_pc; m_nxt1 = n_nxt1; m_nxt2 = n_nxt2; m_movc = n_movc;
        m_mode = n_mode; m_fetch = n_fetch; m_flush = n_flush;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        do_reset();
        checks++; if (im_bus.im_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", im_bus.im_addr); end
        checks++; if (nxt_pc_IM_ID !== 16'h0000) begin errors++; $display("FAIL reset_nxt_im_id: got %h want 0000", nxt_pc_IM_ID); end
        checks++; if (nxt_pc_ID_EX !== 16'h0000) begin errors++; $display("FAIL reset_nxt_id_ex: got %h want 0000", nxt_pc_ID_EX); end
        checks++; if (movc_data_DM_WB !== 16'h0000) begin errors++; $display("FAIL reset_movc: got %h want 0000", movc_data_DM_WB); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (instr !== mem[0]) begin errors++; $display("FAIL reset_instr: got %h want %h", instr, mem[0]); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            checks++; if (im_bus.im_addr !== 16'(i)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, im_bus.im_addr, 16'(i)); end
            tick();
        end
        checks++; if (im_bus.im_addr !== 16'd4) begin errors++; $display("FAIL seq_addr4: got %h want 0004", im_bus.im_addr); end
        checks++; if (nxt_pc_ID_EX !== 16'd3) begin errors++; $display("FAIL seq_nxt_id_ex: got %h want 0003", nxt_pc_ID_EX); end
        checks++; if (nxt_pc_IM_ID !== 16'd4) begin errors++; $display("FAIL seq_nxt_im_id: got %h want 0004", nxt_pc_IM_ID); end
    endtask

    task automatic test_stall();
        tick();
        stall_IM_ID = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (im_bus.im_addr !== 16'd5) begin errors++; $display("FAIL stall_pc%0d: got %h want 0005", i, im_bus.im_addr); end
            checks++; if (nxt_pc_IM_ID !== m_nxt1) begin errors++; $display("FAIL stall_nxt%0d: got %h want %h", i, nxt_pc_IM_ID, m_nxt1); end
        end
        stall_IM_ID = 0;
        tick();
        checks++; if (im_bus.im_addr !== 16'd6) begin errors++; $display("FAIL stall_release: got %h want 0006", im_bus.im_addr); end
    endtask

    task automatic test_flow_change();
        flow_change_ID_EX = 1; dst_ID_EX = 16'h0040; stall_IM_ID = 1;
        tick();
        set_idle();
        #1;
        checks++; if (im_bus.im_addr !== 16'h0040) begin errors++; $display("FAIL fc_target: got %h want 0040", im_bus.im_addr); end
        checks++; if (nxt_pc_IM_ID !== m_nxt1) begin errors++; $display("FAIL fc_nxt_held: got %h want %h", nxt_pc_IM_ID, m_nxt1); end
    endtask

    task automatic test_movc();
        logic [15:0] pc_hold;
        LWI_instr_EX_DM = 1; movc_addr_EX_DM = 16'h0123;
        tick();
        LWI_instr_EX_DM = 0;
        #1;
        pc_hold = m_pc;
        checks++; if (im_bus.im_addr !== 16'h0123) begin errors++; $display("FAIL movc_addr: got %h want 0123", im_bus.im_addr); end
        checks++; if (instr !== 17'h00000) begin errors++; $display("FAIL movc_bubble: got %h want 00000", instr); end
        tick();
        checks++; if (movc_data_DM_WB !== 16'hABCD) begin errors++; $display("FAIL movc_data: got %h want abcd", movc_data_DM_WB); end
        checks++; if (im_bus.im_addr !== pc_hold) begin errors++; $display("FAIL movc_pc_held: got %h want %h", im_bus.im_addr, pc_hold); end
        // LWI held into the MOVC cycle must not start a second read
        LWI_instr_EX_DM = 1;
        tick();
        tick();
        LWI_instr_EX_DM = 0;
        #1;
        checks++; if (im_bus.im_addr !== exp_addr()) begin errors++; $display("FAIL movc_no_b2b_addr: got %h want %h", im_bus.im_addr, exp_addr()); end
        checks++; if (instr !== exp_instr()) begin errors++; $display("FAIL movc_no_b2b_instr: got %h want %h", instr, exp_instr()); end
        // Flow change together with the MOVC request
        LWI_instr_EX_DM = 1; flow_change_ID_EX = 1; dst_ID_EX = 16'h0200; movc_addr_EX_DM = 16'h0050;
        tick();
        LWI_instr_EX_DM = 0; flow_change_ID_EX = 0;
        #1;
        checks++; if (im_bus.im_addr !== 16'h0050) begin errors++; $display("FAIL movc_fc_addr: got %h want 0050", im_bus.im_addr); end
        tick();
        checks++; if (im_bus.im_addr !== 16'h0200) begin errors++; $display("FAIL movc_fc_pc: got %h want 0200", im_bus.im_addr); end
        checks++; if (movc_data_DM_WB !== mem[16'h0050][15:0]) begin errors++; $display("FAIL movc_fc_data: got %h want %h", movc_data_DM_WB, mem[16'h0050][15:0]); end
        // Reset in the middle of a MOVC aborts the read
        LWI_instr_EX_DM = 1; movc_addr_EX_DM = 16'h0123;
        tick();
        set_idle();
        do_reset();
        tick();
        checks++; if (movc_data_DM_WB !== 16'h0000) begin errors++; $display("FAIL movc_reset_abort: got %h want 0000", movc_data_DM_WB); end
        checks++; if (im_bus.im_addr !== 16'h0001) begin errors++; $display("FAIL movc_reset_pc: got %h want 0001", im_bus.im_addr); end
    endtask

    task automatic test_wrap_halt();
        logic [15:0] frozen;
        flow_change_ID_EX = 1; dst_ID_EX = 16'hFFFF;
        tick();
        flow_change_ID_EX = 0;
        checks++; if (im_bus.im_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre: got %h want ffff", im_bus.im_addr); end
        tick();
        checks++; if (im_bus.im_addr !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", im_bus.im_addr); end
        checks++; if (nxt_pc_IM_ID !== 16'h0000) begin errors++; $display("FAIL wrap_nxt: got %h want 0000", nxt_pc_IM_ID); end
        hlt_DM_WB = 1;
        tick();
        hlt_DM_WB = 0;
        frozen = m_pc;
        for (int i = 0; i < 10; i++) begin
            stall_IM_ID = 1'($urandom); flow_change_ID_EX = 1'($urandom);
            LWI_instr_EX_DM = 1'($urandom); dst_ID_EX = 16'($urandom);
            tick();
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag%0d: got %b want 1", i, halted); end
            checks++; if (im_bus.im_addr !== frozen) begin errors++; $display("FAIL halt_pc%0d: got %h want %h", i, im_bus.im_addr, frozen); end
            checks++; if (instr !== 17'h00000) begin errors++; $display("FAIL halt_instr%0d: got %h want 00000", i, instr); end
        end
        // Halt arriving during a MOVC still completes the read
        set_idle();
        do_reset();
        LWI_instr_EX_DM = 1; movc_addr_EX_DM = 16'h0123;
        tick();
        LWI_instr_EX_DM = 0; hlt_DM_WB = 1;
        tick();
        hlt_DM_WB = 0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_in_movc_flag: got %b want 1", halted); end
        checks++; if (movc_data_DM_WB !== 16'hABCD) begin errors++; $display("FAIL halt_in_movc_data: got %h want abcd", movc_data_DM_WB); end
        set_idle();
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 4; ep++) begin
            set_idle();
            do_reset();
            for (int n = 0; n < 200; n++) begin
                stall_IM_ID       = ($urandom_range(3) == 0);
                flow_change_ID_EX = ($urandom_range(7) == 0);
                dst_ID_EX         = 16'($urandom);
                LWI_instr_EX_DM   = ($urandom_range(5) == 0);
                movc_addr_EX_DM   = 16'($urandom);
                hlt_DM_WB         = ($urandom_range(119) == 0);
                #1;
                checks++; if (im_bus.im_addr !== exp_addr()) begin errors++; $display("FAIL rnd_addr e%0d c%0d: got %h want %h", ep, n, im_bus.im_addr, exp_addr()); end
                checks++; if (instr !== exp_instr()) begin errors++; $display("FAIL rnd_instr e%0d c%0d: got %h want %h", ep, n, instr, exp_instr()); end
                checks++; if (nxt_pc_IM_ID !== m_nxt1) begin errors++; $display("FAIL rnd_nxt_im_id e%0d c%0d: got %h want %h", ep, n, nxt_pc_IM_ID, m_nxt1); end
                checks++; if (nxt_pc_ID_EX !== m_nxt2) begin errors++; $display("FAIL rnd_nxt_id_ex e%0d c%0d: got %h want %h", ep, n, nxt_pc_ID_EX, m_nxt2); end
                checks++; if (movc_data_DM_WB !== m_movc) begin errors++; $display("FAIL rnd_movc e%0d c%0d: got %h want %h", ep, n, movc_data_DM_WB, m_movc); end
                checks++; if (halted !== (m_mode == M_HALT)) begin errors++; $display("FAIL rnd_halted e%0d c%0d: got %b want %b", ep, n, halted, m_mode == M_HALT); end
`ifdef IF_PERF_CNT_EN
                checks++; if (fetch_cnt !== m_fetch) begin errors++; $display("FAIL rnd_fetch_cnt e%0d c%0d: got %0d want %0d", ep, n, fetch_cnt, m_fetch); end
                checks++; if (flush_cnt !== m_flush) begin errors++; $display("FAIL rnd_flush_cnt e%0d c%0d: got %0d want %0d", ep, n, flush_cnt, m_flush); end
`endif
                tick();
            end
        end
        set_idle();
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        logic [31:0] f_snap;
        logic [15:0] c_snap;
        set_idle();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            flow_change_ID_EX = (i == 5 || i == 12);
            dst_ID_EX = 16'h0300 + 16'(i);
            tick();
        end
        flow_change_ID_EX = 0;
        checks++; if (fetch_cnt !== 32'd20) begin errors++; $display("FAIL perf_fetch: got %0d want 20", fetch_cnt); end
        checks++; if (flush_cnt !== 16'd2) begin errors++; $display("FAIL perf_flush: got %0d want 2", flush_cnt); end
        hlt_DM_WB = 1;
        tick();
        hlt_DM_WB = 0;
        f_snap = m_fetch;
        c_snap = m_flush;
        flow_change_ID_EX = 1;
        repeat (5) tick();
        flow_change_ID_EX = 0;
        checks++; if (fetch_cnt !== f_snap) begin errors++; $display("FAIL perf_fetch_frozen: got %0d want %0d", fetch_cnt, f_snap); end
        checks++; if (flush_cnt !== c_snap) begin errors++; $display("FAIL perf_flush_frozen: got %0d want %0d", flush_cnt, c_snap); end
    endtask
`endif

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 17'($urandom);
        mem[16'h0123] = 17'h1ABCD;
        test_reset();
        test_sequential();
        test_stall();
        test_flow_change();
        test_movc();
        test_wrap_halt();
        test_random();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
